// File: rtl/btb_file.sv
// BTB storage: 8 two-way sets with per-set LRU, IF lookup, EX read-modify-write, flush invalidation engine.
// Optional `BTB_BYPASS_EN forwards a same-cycle EX write to the IF read port.
module btb_file #(
  parameter int NUM_SETS = 8,
  parameter int SET_W    = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          read_index,
  output logic [SET_W-1:0]    read_set,
  input  logic [2:0]          update_index,
  output logic [SET_W-1:0]    update_set,
  output logic [NUM_SETS-1:0] LRU,
  input  logic                write_en,
  input  logic [SET_W-1:0]    write_set,
  input  logic                next_LRU_write,
  input  logic                flush_req,
  output logic                busy
);

  localparam int IDX_W     = 3;
  localparam int WAY1_V    = SET_W - 1;
  localparam int WAY2_V    = SET_W / 2 - 1;
  localparam logic [SET_W-1:0] VALID_MASK = (SET_W'(1) << WAY1_V) | (SET_W'(1) << WAY2_V);
  localparam logic [IDX_W-1:0] LAST_SET   = IDX_W'(NUM_SETS - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [SET_W-1:0]    sets [NUM_SETS];
  logic [NUM_SETS-1:0] lru_q;
  logic [SET_W-1:0]    array_read;

  // EX writes only land in IDLE; CLEAR walks the sets one per cycle, dropping only the valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        sets[i] <= '0;
      end
      lru_q <= '0;
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_en) begin
            sets[update_index]  <= write_set;
            lru_q[update_index] <= next_LRU_write;
          end
          if (flush_req) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          sets[ptr]  <= sets[ptr] & ~VALID_MASK;
          lru_q[ptr] <= 1'b0;
          ptr        <= ptr + IDX_W'(1);
          if (ptr == LAST_SET) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = (state == CLEAR);
  assign LRU        = lru_q;
  assign array_read = sets[read_index];
  assign update_set = sets[update_index];

  // IF sees no valid entries mid-flush so it never predicts from half-cleared state.
  always_comb begin
    read_set = busy ? (array_read & ~VALID_MASK) : array_read;
`ifdef BTB_BYPASS_EN
    if (write_en && !busy && (read_index == update_index)) begin
      read_set = write_set;
    end
`endif
  end

endmodule

// File: doc/btb_file.md
# btb_file

Storage stage for the branch target buffer: holds 8 two-way sets (128 bits each) plus the per-set LRU vector. Serves the IF-stage lookup read and the EX-stage read-modify-write loop. It supplies the current set and LRU to the EX-stage BTB write logic and commits the returned set and LRU bit on the next clock edge. It also contains a sequential invalidation engine that clears every valid bit on a flush request.

## Interface
- NUM_SETS, 8: number of sets; index width is 3 (fixed by this value).
- SET_W, 128: set width. Way 1 occupies [127:64] and way 2 occupies [63:0]. The valid bits are 127 and 63.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- read_index  in  3  IF-stage set index.
- read_set  out  128  IF-stage set contents (combinational).
- update_index  in  3  EX-stage set index.
- update_set  out  128  current contents of set update_index (combinational), fed to the write logic.
- LRU  out  8  LRU vector; bit i belongs to set i.
- write_en  in  1  commit write_set / next_LRU_write to set update_index.
- write_set  in  128  new set contents from the write logic.
- next_LRU_write  in  1  new LRU bit for set update_index.
- flush_req  in  1  one-cycle pulse; starts invalidation.
- busy  out  1  high while invalidation runs.

## Operation
- Storage: 8×128 register array, sets[0..7], plus an 8-bit LRU register.
- Write, IDLE state: on a rising edge with write_en=1:
  - sets[update_index] <= write_set
  - LRU[update_index] <= next_LRU_write
- Read: read_set = sets[read_index]; update_set = sets[update_index]. Both are pure array reads; no forwarding except as described under Configuration.
- Invalidation FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on flush_req=1. ptr is loaded with 0.
  - In CLEAR, on each edge: bits 127 and 63 of sets[ptr] are cleared, LRU[ptr] <= 0, and ptr increments. All other bits of the set are preserved.
  - CLEAR -> IDLE on the edge that clears ptr=7.
- busy = (state == CLEAR).
- While busy:
  - write_en is ignored; the write is dropped, not queued.
  - flush_req is ignored.
  - read_set is returned with bits 127 and 63 forced to 0, so IF makes no prediction.
  - update_set is unmasked.
- Simultaneous write_en and flush_req in IDLE: the write commits on that edge and CLEAR begins next cycle, so the written entry is invalidated later.
- Same update_index written on consecutive cycles: the last write wins. update_set reflects each write one cycle later.
- rst asserted at any time, including mid-CLEAR:
  - all sets go to 0, LRU goes to 0, state goes to IDLE, ptr goes to 0, busy goes to 0, immediately.

## Timing
- Read latency: 0 cycles, combinational from the index.
- Write latency: the value is visible on update_set and read_set at the edge after write_en; read-after-write is 1 cycle without bypass.
- Flush: busy rises on the edge after flush_req and stays high for exactly 8 cycles. The first write accepted again is the one presented in the cycle after busy falls.
- Reset values: read_set = 0, update_set = 0, LRU = 8'h00, busy = 0.

## Configuration
- BTB_BYPASS_EN defined: when write_en=1, busy=0, and read_index == update_index, read_set returns write_set in the same cycle (bits 127/63 of write_set pass through). update_set is never bypassed.
- BTB_BYPASS_EN undefined: read_set always reflects the array; the new value appears one cycle later.

## Test plan
- Reset, then read all indices: every read_set and update_set is 0, LRU = 8'h00, busy = 0.
- Write set 3 with write_set = {1'b1, 27'h0000123, 32'h0000_0400, 2'b01, 2'b00, 64'h0} and next_LRU_write = 1: next cycle update_set (index 3) returns that value and LRU = 8'h08.
- With BTB_BYPASS_EN, in the same cycle as the set-3 write, read_index = 3: read_set returns the new value in that cycle. Without the macro, it returns 0 that cycle.
- Fill all 8 sets with valid entries and set LRU = 8'hFF, then pulse flush_req:
  - busy is high for 8 cycles
  - a write_en on set 0 during cycle 4 is dropped
  - afterwards every set has bits 127/63 = 0 with the tag/target fields intact, and LRU = 8'h00
- Assert write_en on set 5 with flush_req in the same cycle: set 5 is written, then invalidated by the following CLEAR pass.
- Assert rst during the 4th CLEAR cycle: busy drops immediately, all sets = 0, and a write on the cycle after release commits normally.
